// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared FSM states, op-field bit positions and requester ids
// for the shared restoring divider.
package div_sched_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int   OP_QUOT_BIT = 0;
    localparam int   OP_UNS_BIT  = 1;
    localparam logic ID_CORE     = 1'b0;
    localparam logic ID_ACC      = 1'b1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on {A,Q} against divisor M.
module div_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] i_aq,
    input  logic [W-1:0]   i_m,
    output logic [2*W-1:0] o_aq
);
    logic [W:0] w_a_sh;
    logic [W:0] w_trial;
    // The bit shifted out of A is kept, so the trial never wraps for divisors >= 2^(W-1).
    assign w_a_sh  = i_aq[2*W-1:W-1];
    assign w_trial = w_a_sh - {1'b0, i_m};
    assign o_aq    = {w_trial[W] ? w_a_sh[W-1:0] : w_trial[W-1:0], i_aq[W-2:0], ~w_trial[W]};
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin core/accelerator divider front end with a sequential restoring
// divider; optional last-result reuse when DIV_SCHED_PAIR_CACHE_EN is defined.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [1:0]        core_op,
    input  logic [LENGTH-1:0] core_a,
    input  logic [LENGTH-1:0] core_b,
    input  logic              acc_req_valid,
    output logic              acc_req_ready,
    input  logic [1:0]        acc_op,
    input  logic [LENGTH-1:0] acc_a,
    input  logic [LENGTH-1:0] acc_b,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [LENGTH-1:0] resp_data,
    output logic              resp_dbz,
    output logic              busy
);
    localparam int CW = $clog2(LENGTH);

    state_t              r_state, w_next;
    logic                r_prio_acc;
    logic                w_grant_acc, w_accept, w_hit;
    logic [1:0]          w_op;
    logic [LENGTH-1:0]   w_a, w_b;
    logic                w_a_neg, w_b_neg, w_b_zero;
    logic [2*LENGTH-1:0] r_aq, w_aq_step;
    logic [LENGTH-1:0]   r_m;
    logic [CW-1:0]       r_cnt;
    logic                r_quot, r_id, r_neg_q, r_neg_r, r_dbz;
    logic [LENGTH-1:0]   w_quot_calc, w_rem_calc, w_quot, w_rem;
    logic                w_dbz;
    logic                r_resp_valid, r_resp_id, r_resp_dbz;
    logic [LENGTH-1:0]   r_resp_data;

    assign w_grant_acc = acc_req_valid & (~core_req_valid | r_prio_acc);
    assign w_accept    = (r_state == IDLE) & (core_req_valid | acc_req_valid);
    assign w_op        = w_grant_acc ? acc_op : core_op;
    assign w_a         = w_grant_acc ? acc_a : core_a;
    assign w_b         = w_grant_acc ? acc_b : core_b;
    assign w_a_neg     = ~w_op[OP_UNS_BIT] & w_a[LENGTH-1];
    assign w_b_neg     = ~w_op[OP_UNS_BIT] & w_b[LENGTH-1];
    assign w_b_zero    = (w_b == '0);

    div_step #(.W(LENGTH)) u_step (
        .i_aq (r_aq),
        .i_m  (r_m),
        .o_aq (w_aq_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        core_req_ready = 1'b0;
        acc_req_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                core_req_ready = core_req_valid & ~w_grant_acc;
                acc_req_ready  = w_grant_acc;
                if (w_accept) w_next = (w_b_zero | w_hit) ? FIX : CALC;
            end
            CALC:    w_next = (r_cnt == CW'(LENGTH - 1)) ? FIX : CALC;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Divide-by-zero forces both halves to zero regardless of the magnitudes held.
    assign w_quot_calc = r_dbz ? '0 : (r_neg_q ? -r_aq[LENGTH-1:0] : r_aq[LENGTH-1:0]);
    assign w_rem_calc  = r_dbz ? '0 : (r_neg_r ? -r_aq[2*LENGTH-1:LENGTH] : r_aq[2*LENGTH-1:LENGTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_acc   <= 1'b0;
            r_aq         <= '0;
            r_m          <= '0;
            r_cnt        <= '0;
            r_quot       <= 1'b0;
            r_id         <= ID_CORE;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dbz        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= ID_CORE;
            r_resp_data  <= '0;
            r_resp_dbz   <= 1'b0;
        end else begin
            r_resp_valid <= (r_state == FIX);
            if (w_accept) begin
                r_prio_acc <= ~w_grant_acc;
                r_id       <= w_grant_acc ? ID_ACC : ID_CORE;
                r_quot     <= w_op[OP_QUOT_BIT];
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_dbz      <= w_b_zero;
                r_m        <= w_b_neg ? -w_b : w_b;
                r_aq       <= {{LENGTH{1'b0}}, w_a_neg ? -w_a : w_a};
                r_cnt      <= '0;
            end else if (r_state == CALC) begin
                r_aq  <= w_aq_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == FIX) begin
                r_resp_id   <= r_id;
                r_resp_dbz  <= w_dbz;
                r_resp_data <= r_quot ? w_quot : w_rem;
            end
        end
    end

`ifdef DIV_SCHED_PAIR_CACHE_EN
    logic              r_c_valid, r_c_uns, r_c_dbz, r_hit, r_uns;
    logic [LENGTH-1:0] r_c_a, r_c_b, r_c_q, r_c_r, r_a_raw, r_b_raw;

    assign w_hit  = r_c_valid & (w_a == r_c_a) & (w_b == r_c_b) & (w_op[OP_UNS_BIT] == r_c_uns);
    assign w_quot = r_hit ? r_c_q : w_quot_calc;
    assign w_rem  = r_hit ? r_c_r : w_rem_calc;
    assign w_dbz  = r_hit ? r_c_dbz : r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_valid <= 1'b0;
            r_c_uns   <= 1'b0;
            r_c_dbz   <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_q     <= '0;
            r_c_r     <= '0;
            r_hit     <= 1'b0;
            r_uns     <= 1'b0;
            r_a_raw   <= '0;
            r_b_raw   <= '0;
        end else begin
            if (w_accept) begin
                r_hit   <= w_hit;
                r_uns   <= w_op[OP_UNS_BIT];
                r_a_raw <= w_a;
                r_b_raw <= w_b;
            end
            if (r_state == FIX) begin
                r_c_valid <= 1'b1;
                r_c_uns   <= r_uns;
                r_c_dbz   <= w_dbz;
                r_c_a     <= r_a_raw;
                r_c_b     <= r_b_raw;
                r_c_q     <= w_quot;
                r_c_r     <= w_rem;
            end
        end
    end
`else
    assign w_hit  = 1'b0;
    assign w_quot = w_quot_calc;
    assign w_rem  = w_rem_calc;
    assign w_dbz  = r_dbz;
`endif

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_dbz   = r_resp_dbz;
    assign busy       = (r_state != IDLE);
endmodule
